// File: rtl/sha_pkg.sv
// Shared types, constants and word-formatting helpers for the SHA-1 message sequencer.
package sha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_RUN,
        ST_WAIT
    } sha_state_t;

    localparam int          SHA1_BLOCK_WORDS = 16;
    localparam logic [31:0] SHA1_PAD_WORD    = 32'h80000000;
    localparam int          SHA1_DIGEST_W    = 160;
    localparam int          SHA1_LEN_W       = 64;

    // Keep the leading valid bytes of a final word and place the 0x80 marker right after them.
    function automatic logic [31:0] sha_mask_last(input logic [31:0] data, input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    return SHA1_PAD_WORD;
            3'd1:    return {data[31:24], 24'h800000};
            3'd2:    return {data[31:16], 16'h8000};
            3'd3:    return {data[31:8], 8'h80};
            default: return data;
        endcase
    endfunction

    function automatic logic [SHA1_LEN_W-1:0] sha_word_bits(input logic last, input logic [2:0] nbytes);
        if (!last || nbytes >= 3'd4) begin
            return SHA1_LEN_W'(32);
        end
        return {58'd0, nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha_block_buffer.sv
// 16 x 32-bit block register file; word 0 appears in the top bits of the flattened block.
module sha_block_buffer
    import sha_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_idx,
    input  logic [31:0]                    wr_data,
    output logic [SHA1_BLOCK_WORDS*32-1:0] block
);

    logic [31:0] mem [SHA1_BLOCK_WORDS];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < SHA1_BLOCK_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < SHA1_BLOCK_WORDS; g++) begin : g_flat
        assign block[(SHA1_BLOCK_WORDS-1-g)*32 +: 32] = mem[g];
    end

endmodule

// File: rtl/sha_msg_sequencer.sv
// Streams message words into 512-bit SHA-1 blocks, applies padding/length and drives the hash core.
module sha_msg_sequencer
    import sha_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_last,
    input  logic [2:0]                     s_bytes,
    input  logic                           abort,
    output logic                           core_start,
    output logic                           core_init,
    output logic [SHA1_BLOCK_WORDS*32-1:0] core_block,
    input  logic                           core_done,
    input  logic [SHA1_DIGEST_W-1:0]       core_digest,
    output logic [SHA1_DIGEST_W-1:0]       digest,
    output logic                           done,
    output logic                           busy,
    output logic                           err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    sha_state_t            state, state_nx;
    logic [4:0]            idx;
    logic                  first;
    logic                  msg_last;
    logic                  pad_marker;
    logic                  len_ok;
    logic                  len_done;
    logic [SHA1_LEN_W-1:0] len;
    logic [TW-1:0]         timer;

    logic        xfer;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] pad_word;
    logic        tmo_hit;
    logic        finish_hit;
    logic        ctrl_clr;

    assign s_ready    = (state == ST_IDLE) || (state == ST_FILL);
    assign busy       = (state != ST_IDLE);
    assign xfer       = s_valid && s_ready;
    assign tmo_hit    = (state == ST_WAIT) && !core_done && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign finish_hit = (state == ST_WAIT) && core_done && len_done;
    assign ctrl_clr   = abort || tmo_hit || finish_hit;

    sha_block_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (abort),
        .wr_en   (wr_en),
        .wr_idx  (idx[3:0]),
        .wr_data (wr_data),
        .block   (core_block)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wr_en      = 1'b0;
        wr_data    = '0;
        core_start = 1'b0;
        core_init  = 1'b0;
        pad_word   = '0;
        if (pad_marker) begin
            pad_word = SHA1_PAD_WORD;
        end else if (len_ok && idx == 5'd14) begin
            pad_word = len[63:32];
        end else if (len_ok && idx == 5'd15) begin
            pad_word = len[31:0];
        end
        case (state)
            ST_IDLE, ST_FILL: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_data = s_last ? sha_mask_last(s_data, s_bytes) : s_data;
                    if (s_last) begin
                        state_nx = ST_PAD;
                    end else if (idx == 5'd15) begin
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                // A block already full of data/marker goes straight to the core; padding resumes afterwards.
                if (idx[4]) begin
                    state_nx = ST_RUN;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = pad_word;
                    if (idx == 5'd15) begin
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                core_start = 1'b1;
                core_init  = first;
                state_nx   = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    if (len_done) begin
                        state_nx = ST_IDLE;
                    end else if (msg_last) begin
                        state_nx = ST_PAD;
                    end else begin
                        state_nx = ST_FILL;
                    end
                end else if (tmo_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx   = ST_IDLE;
            wr_en      = 1'b0;
            core_start = 1'b0;
            core_init  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            first      <= 1'b0;
            msg_last   <= 1'b0;
            pad_marker <= 1'b0;
            len_ok     <= 1'b0;
            len_done   <= 1'b0;
            len        <= '0;
            timer      <= '0;
            digest     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finish_hit && !abort) begin
                digest <= core_digest;
                done   <= 1'b1;
            end
            if (tmo_hit && !abort) begin
                err <= 1'b1;
            end
            if (ctrl_clr) begin
                idx        <= '0;
                first      <= 1'b0;
                msg_last   <= 1'b0;
                pad_marker <= 1'b0;
                len_ok     <= 1'b0;
                len_done   <= 1'b0;
                len        <= '0;
                timer      <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_FILL: begin
                        if (xfer) begin
                            idx <= idx + 5'd1;
                            len <= ((state == ST_IDLE) ? '0 : len) + sha_word_bits(s_last, s_bytes);
                            if (state == ST_IDLE) begin
                                first <= 1'b1;
                            end
                            if (s_last) begin
                                msg_last   <= 1'b1;
                                pad_marker <= (s_bytes >= 3'd4);
                                // Length fits only if the marker word sits at index 13 or below.
                                len_ok     <= (s_bytes >= 3'd4) ? (idx <= 5'd12) : (idx <= 5'd13);
                            end
                        end
                    end
                    ST_PAD: begin
                        if (!idx[4]) begin
                            idx        <= idx + 5'd1;
                            pad_marker <= 1'b0;
                            if (len_ok && idx == 5'd15) begin
                                len_done <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        first <= 1'b0;
                        timer <= TW'(1);
                    end
                    ST_WAIT: begin
                        if (core_done) begin
                            idx <= '0;
                            if (msg_last) begin
                                len_ok <= 1'b1;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// Randomized scoreboard bench: a byte-level SHA-1 padding/hash model predicts blocks and digests.
module tb_sha_msg_sequencer;
    import sha_pkg::*;

    localparam int TMO = 64;
    localparam logic [159:0] H_INIT   = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] DIG_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_NONE = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

    typedef logic [511:0] blk_t;
    typedef logic [7:0]   bq_t [$];
    typedef blk_t         bkq_t [$];

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic         abort;
    logic         core_start;
    logic         core_init;
    logic [511:0] core_block;
    logic         core_done;
    logic [159:0] core_digest;
    logic [159:0] digest;
    logic         done;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t_start = 0;
    int spur_req = 0;
    int spur_seen = 0;
    bit withhold = 1'b0;
    logic [159:0] last_dig;
    logic [159:0] hc;

    blk_t         exp_blk_q [$];
    bit           exp_init_q [$];
    logic [159:0] exp_dig_q [$];
    blk_t         log_blk [$];
    bit           log_init [$];

    sha_msg_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_bytes     (s_bytes),
        .abort       (abort),
        .core_start  (core_start),
        .core_init   (core_init),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_digest (core_digest),
        .digest      (digest),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic logic [31:0] word_of(input blk_t b, input int i);
        return b[511-32*i -: 32];
    endfunction

    function automatic logic [159:0] sha1_comp(input logic [159:0] h, input blk_t b);
        logic [31:0] w [80];
        logic [31:0] a, bb, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = h[159:128]; bb = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin f = (bb & c) | (~bb & d); k = 32'h5a827999; end
            else if (i < 40) begin f = bb ^ c ^ d; k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
            else begin f = bb ^ c ^ d; k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Standard byte-level SHA-1 padding: 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    function automatic bkq_t make_blocks(input bq_t m);
        bq_t         p;
        bkq_t        r;
        blk_t        cur;
        logic [63:0] bl;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) cur[511-8*j -: 8] = p[64*bi+j];
            r.push_back(cur);
        end
        return r;
    endfunction

    task automatic put_word(input logic [31:0] d, input bit l, input logic [2:0] nb, input int gap_pct);
        int cnt;
        @(negedge clk);
        if ($urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        s_valid = 1'b1; s_data = d; s_last = l; s_bytes = nb;
        cnt = 0;
        while (!s_ready) begin
            @(negedge clk);
            cnt++;
            if (cnt > 500) begin
                tests++; fails++;
                $display("FAIL s_ready_wait: s_ready got 0 expected 1 within 500 cycles");
                finish_sim();
            end
        end
        @(posedge clk);
    endtask

    task automatic send_msg(input bq_t m, input bit expect_done, input int gap_pct,
                            input bit extra_ok, input bit drop);
        bkq_t         bl;
        logic [159:0] h;
        logic [31:0]  w;
        int           n, nfull, rem;
        bit           use_extra, l;
        bl = make_blocks(m);
        h  = H_INIT;
        foreach (bl[i]) begin
            exp_blk_q.push_back(bl[i]);
            exp_init_q.push_back(i == 0);
            h = sha1_comp(h, bl[i]);
        end
        if (expect_done) exp_dig_q.push_back(h);
        n = m.size(); nfull = n / 4; rem = n % 4;
        use_extra = (n == 0) || (rem == 0 && extra_ok && $urandom_range(0, 1) == 1);
        for (int i = 0; i < nfull; i++) begin
            w = {m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]};
            l = (i == nfull - 1) && (rem == 0) && !use_extra;
            put_word(w, l, l ? 3'd4 : 3'($urandom_range(0, 7)), gap_pct);
        end
        if (rem != 0) begin
            w = $urandom;
            for (int j = 0; j < rem; j++) w[31-8*j -: 8] = m[4*nfull+j];
            put_word(w, 1'b1, 3'(rem), gap_pct);
        end else if (use_extra) begin
            put_word($urandom, 1'b1, 3'd0, gap_pct);
        end
        if (drop) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (exp_dig_q.size() != 0 || exp_blk_q.size() != 0 || busy || done) begin
            @(negedge clk);
            cnt++;
            if (cnt > 3000) begin
                tests++; fails++;
                $display("FAIL idle_wait: pending blocks %0d digests %0d expected 0", exp_blk_q.size(), exp_dig_q.size());
                finish_sim();
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Hash core model and block monitor.
    initial begin
        blk_t cap;
        bit   bad;
        core_done = 1'b0; core_digest = '0; hc = H_INIT;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start) begin
                cap = core_block;
                t_start = cyc;
                log_blk.push_back(cap);
                log_init.push_back(core_init);
                if (exp_blk_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL core_start: got unexpected block %0h expected none", cap);
                end else begin
                    chk("core_block", cap, exp_blk_q.pop_front());
                    chk("core_init", 512'(core_init), 512'(exp_init_q.pop_front()));
                end
                hc = sha1_comp(core_init ? H_INIT : hc, cap);
                if (!withhold) begin
                    bad = 1'b0;
                    repeat ($urandom_range(1, 6)) begin
                        @(negedge clk);
                        if (s_ready || core_start || core_block !== cap) bad = 1'b1;
                    end
                    chk("wait_hold", 512'(bad), 512'(0));
                    core_done = 1'b1;
                    core_digest = hc;
                end
            end else if (spur_req != spur_seen) begin
                spur_seen++;
                core_done = 1'b1;
                core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Digest monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                last_dig = digest;
                if (exp_dig_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 digest %0h expected no done", digest);
                end else begin
                    chk("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        tests++; fails++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_sim();
    end

    initial begin
        bq_t m;
        int  d0, cnt;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 512'(s_ready), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_digest", 512'(digest), 512'(0));
        chk("rst_block", core_block, 512'(0));
        chk("rst_core_start", 512'(core_start), 512'(0));
        chk("rst_core_init", 512'(core_init), 512'(0));

        // Stray core_done while idle must be ignored.
        d0 = done_cnt;
        spur_req++;
        repeat (5) @(negedge clk);
        chk("spurious_done", 512'(done_cnt - d0), 512'(0));
        chk("spurious_busy", 512'(busy), 512'(0));

        // "abc"
        log_blk.delete(); log_init.delete();
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, 0, 1'b0, 1'b1);
        wait_idle();
        chk("abc_nblk", 512'(log_blk.size()), 512'(1));
        chk("abc_w0", 512'(word_of(log_blk[0], 0)), 512'(32'h61626380));
        chk("abc_w15", 512'(word_of(log_blk[0], 15)), 512'(32'h00000018));
        chk("abc_init", 512'(log_init[0]), 512'(1));
        chk("abc_digest", 512'(last_dig), 512'(DIG_ABC));

        // Empty message
        log_blk.delete(); log_init.delete();
        m.delete();
        send_msg(m, 1'b1, 0, 1'b0, 1'b1);
        wait_idle();
        chk("empty_w0", 512'(word_of(log_blk[0], 0)), 512'(32'h80000000));
        chk("empty_rest", 512'(log_blk[0][479:0]), 512'(0));
        chk("empty_digest", 512'(last_dig), 512'(DIG_NONE));

        // 14 full words: marker spills to index 14, length in a second block
        log_blk.delete(); log_init.delete();
        m = rand_bytes(56);
        send_msg(m, 1'b1, 0, 1'b0, 1'b1);
        wait_idle();
        chk("w14_nblk", 512'(log_blk.size()), 512'(2));
        chk("w14_b0w14", 512'(word_of(log_blk[0], 14)), 512'(32'h80000000));
        chk("w14_b0w15", 512'(word_of(log_blk[0], 15)), 512'(0));
        chk("w14_b1w15", 512'(word_of(log_blk[1], 15)), 512'(32'h000001c0));
        chk("w14_b1lo", 512'(log_blk[1][511:32]), 512'(0));
        chk("w14_init0", 512'(log_init[0]), 512'(1));
        chk("w14_init1", 512'(log_init[1]), 512'(0));

        // Abort after 7 words (with a word offered in the abort cycle), then "abc"
        log_blk.delete(); log_init.delete();
        d0 = done_cnt;
        for (int i = 0; i < 7; i++) put_word($urandom, 1'b0, 3'd4, 0);
        @(negedge clk);
        s_valid = 1'b1; s_data = $urandom; s_last = 1'b0; abort = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; abort = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, 0, 1'b0, 1'b1);
        wait_idle();
        chk("abort_dones", 512'(done_cnt - d0), 512'(1));
        chk("abort_nblk", 512'(log_blk.size()), 512'(1));
        chk("abort_init", 512'(log_init[0]), 512'(1));
        chk("abort_digest", 512'(last_dig), 512'(DIG_ABC));

        // 20-word message with s_valid held high straight into the next message
        m = rand_bytes(80);
        send_msg(m, 1'b1, 0, 1'b0, 1'b0);
        m = rand_bytes(23);
        send_msg(m, 1'b1, 0, 1'b0, 1'b1);
        wait_idle();

        // Randomized messages
        for (int k = 0; k < 20; k++) begin
            m = rand_bytes($urandom_range(0, 140));
            send_msg(m, 1'b1, 30, 1'b1, 1'b1);
            wait_idle();
        end

        // Reset in the middle of a message
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) put_word($urandom, 1'b0, 3'd4, 0);
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_done", 512'(done_cnt - d0), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_ready", 512'(s_ready), 512'(1));

        // Core never answers: timeout
        d0 = done_cnt;
        withhold = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 0, 1'b0, 1'b1);
        cnt = 0;
        while (!err && cnt < TMO + 60) begin
            @(negedge clk);
            cnt++;
        end
        if (!err) begin
            tests++; fails++;
            $display("FAIL timeout_err: err got 0 expected 1 within %0d cycles", TMO + 60);
        end else begin
            chk("timeout_cycles", 512'(cyc - t_start), 512'(TMO));
            chk("timeout_busy", 512'(busy), 512'(0));
        end
        withhold = 1'b0;
        repeat (5) @(negedge clk);
        chk("timeout_nodone", 512'(done_cnt - d0), 512'(0));

        m = rand_bytes(61);
        send_msg(m, 1'b1, 20, 1'b1, 1'b1);
        wait_idle();
        chk("err_sticky", 512'(err), 512'(1));

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared", 512'(err), 512'(0));
        chk("rst2_digest", 512'(digest), 512'(0));
        chk("rst2_block", core_block, 512'(0));

        chk("queues_empty", 512'(exp_blk_q.size() + exp_dig_q.size()), 512'(0));
        finish_sim();
    end

endmodule

// File: doc/sha_msg_sequencer.md
SHA_MSG_SEQUENCER -- requirements
Module: sha_msg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1024: maximum cycles between core_start and core_done before error.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_data  input  32  message word, big-endian (first message byte in [31:24]).
REQ-005 s_valid  input  1  s_data/s_last/s_bytes valid.
REQ-006 s_ready  output  1  sequencer accepts word this cycle.
REQ-007 s_last  input  1  final word of message.
REQ-008 s_bytes  input  3  valid leading bytes in last word, 0..4 (0 legal only with s_last); ignored when s_last=0.
REQ-009 abort  input  1  discard current message.
REQ-010 core_start  output  1  one-cycle pulse: hash core_block.
REQ-011 core_init  output  1  valid with core_start; core reloads H0..H4 before this block.
REQ-012 core_block  output  512  padded block, word 0 in [511:480]; stable from core_start until core_done.
REQ-013 core_done  input  1  one-cycle pulse: core finished block.
REQ-014 core_digest  input  160  core chaining value; valid when core_done=1.
REQ-015 digest  output  160  final hash, held until next done.
REQ-016 done  output  1  one-cycle pulse: digest valid.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 States: IDLE, FILL, PAD, RUN, WAIT; one word accepted or generated per cycle.
REQ-020 s_ready SHALL be 1 only in IDLE and FILL; transfer occurs on s_valid && s_ready.
REQ-021 IDLE: first transfer writes word index 0, sets first=1, goes FILL (or PAD if s_last).
REQ-022 FILL: each transfer writes next index, adds 32 bits (or 8*s_bytes if s_last) to 64-bit length counter.
REQ-023 Non-last 16th word -> RUN; last word -> PAD.
REQ-024 Last word with s_bytes<4: bytes beyond s_bytes zeroed, byte s_bytes set to 0x80, in that same word.
REQ-025 Last word with s_bytes=4: PAD writes 0x80000000 to next index as its first cycle.
REQ-026 PAD: writes zero words one per cycle up to index 13, then length[63:32] at 14, length[31:0] at 15, -> RUN.
REQ-027 If 0x80 word lands at index 14 or 15: zero-fill to 15, RUN, WAIT, then PAD again with a fresh block (words 0..13 zero) carrying length.
REQ-028 RUN: core_start=1 for exactly one cycle, core_init=first, -> WAIT; first cleared.
REQ-029 WAIT: on core_done, word index cleared; -> FILL if message not finished, else digest<=core_digest, done=1 next cycle, -> IDLE.
REQ-030 WAIT timer counts from core_start; reaching TIMEOUT_CYCLES without core_done sets err, -> IDLE, no done.
REQ-031 Length counter wraps modulo 2^64.
REQ-032 abort in any state: next state IDLE, buffer/counters cleared, no done, no core_start; abort wins over simultaneous core_done or transfer.
REQ-033 core_done outside WAIT SHALL be ignored.
REQ-034 err cleared only by reset.

Reset
REQ-035 reset: state IDLE, s_ready=1 after reset deasserts, core_start=0, core_init=0, done=0, busy=0, err=0, digest=0, core_block=0, counters=0.
REQ-036 reset mid-operation SHALL abandon the message with no done pulse.

Structure
REQ-037 Package sha_pkg holds: state enum, SHA1_BLOCK_WORDS=16, SHA1_PAD_WORD=32'h80000000, SHA1_DIGEST_W=160, SHA1_LEN_W=64.
REQ-038 One sub-module sha_block_buffer: 16x32 register file with write index and 512-bit flattened output.

Verification (bench uses team SHA-1 core)
REQ-039 Single word 0x61626300, s_bytes=3, s_last -> one block, word0=0x61626380, word15=0x00000018, digest=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
REQ-040 Single word s_bytes=0, s_last -> word0=0x80000000, words1..15=0, digest=da39a3ee_5e6b4b0d_3255bfef_95601890_afd80709.
REQ-041 14 full words, last s_bytes=4 -> two blocks; block0 words14..15=0x80000000,0; block1 word15=0x000001C0, core_init 1 then 0.
REQ-042 core_done withheld -> err=1 exactly TIMEOUT_CYCLES after core_start, state IDLE, no done.
REQ-043 abort after 7 words, then "abc" message -> only one done, digest as REQ-039, core_init=1.
REQ-044 s_valid held high with back-to-back 20-word message -> s_ready low during PAD/RUN/WAIT, no word lost or duplicated.
